alu_issue_arbiter: RTL and testbench

//  Shares one ALU_module instance between two requesters (e.g. execute stage and

---
 rtl/alu_issue_arbiter.sv | 164 ++++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one multi-cycle ALU between two requesters.
// One op in flight; operands held for ALU_LAT cycles, result returned on valid/ready.
module alu_issue_arbiter #(
   parameter int ALU_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [3:0]  req0_func,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [3:0]  req1_func,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_func,
   input  logic [31:0] alu_result,
   output logic        busy
);

   localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);
   localparam logic [3:0] FUNC_MAX = 4'd8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_e;

   state_e        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   alu_a_q, alu_a_d;
   logic [31:0]   alu_b_q, alu_b_d;
   logic [3:0]    alu_func_q, alu_func_d;
   logic [31:0]   rsp_data_q, rsp_data_d;
   logic          rsp_err_q, rsp_err_d;
   logic          owner_q, owner_d;

   logic          gnt0;
   logic          gnt1;
   logic          acc;
   logic [31:0]   acc_a;
   logic [31:0]   acc_b;
   logic [3:0]    acc_func;
   logic          rsp_hs;

   // Ties go to whichever requester was not granted last.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == S_IDLE) begin
         gnt0 = req0_valid & (~req1_valid | last_grant_q);
         gnt1 = req1_valid & (~req0_valid | ~last_grant_q);
      end
   end

   always_comb begin
      acc      = gnt0 | gnt1;
      acc_a    = gnt1 ? req1_a : req0_a;
      acc_b    = gnt1 ? req1_b : req0_b;
      acc_func = gnt1 ? req1_func : req0_func;
      rsp_hs   = owner_q ? rsp1_ready : rsp0_ready;
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_func_d   = alu_func_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      owner_d      = owner_q;
      unique case (state_q)
         S_IDLE: begin
            if (acc) begin
               owner_d      = gnt1;
               last_grant_d = gnt1;
               if (acc_func <= FUNC_MAX) begin
                  alu_a_d    = acc_a;
                  alu_b_d    = acc_b;
                  alu_func_d = acc_func;
                  cnt_d      = CNT_INIT;
                  state_d    = S_EXEC;
               end else begin
                  // Illegal op never reaches the ALU.
                  rsp_data_d = 32'd0;
                  rsp_err_d  = 1'b1;
                  state_d    = S_RESP;
               end
            end
         end
         S_EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               rsp_data_d = alu_result;
               rsp_err_d  = 1'b0;
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_hs) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         alu_a_q      <= 32'd0;
         alu_b_q      <= 32'd0;
         alu_func_q   <= 4'd0;
         rsp_data_q   <= 32'd0;
         rsp_err_q    <= 1'b0;
         owner_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_func_q   <= alu_func_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         owner_q      <= owner_d;
      end
   end

   // Ready is forced low while reset is asserted, even in IDLE.
   always_comb begin
      req0_ready = gnt0 & rst_n;
      req1_ready = gnt1 & rst_n;
      rsp0_valid = (state_q == S_RESP) & ~owner_q;
      rsp1_valid = (state_q == S_RESP) & owner_q;
      rsp_data   = rsp_data_q;
      rsp_err    = rsp_err_q;
      alu_a      = alu_a_q;
      alu_b      = alu_b_q;
      alu_func   = alu_func_q;
      busy       = (state_q != S_IDLE);
   end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed self-checking bench for alu_issue_arbiter (ALU_LAT=2).
// Includes a behavioural ALU driving alu_result from the registered operands.
module tb_alu_issue_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready;
   logic [31:0] req0_a, req0_b;
   logic [3:0]  req0_func;
   logic        req1_valid, req1_ready;
   logic [31:0] req1_a, req1_b;
   logic [3:0]  req1_func;
   logic        rsp0_valid, rsp0_ready;
   logic        rsp1_valid, rsp1_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_func;
   logic [31:0] alu_result;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_issue_arbiter #(.ALU_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
      .alu_result(alu_result), .busy(busy)
   );

   always_comb begin
      alu_result = 32'd0;
      case (alu_func)
         4'd0: alu_result = alu_a + alu_b;
         4'd1: alu_result = alu_a - alu_b;
         4'd2: alu_result = alu_a & alu_b;
         4'd3: alu_result = alu_a | alu_b;
         4'd4: alu_result = alu_a ^ alu_b;
         4'd5: alu_result = ~alu_a;
         4'd6: alu_result = alu_a << alu_b[0];
         4'd7: alu_result = $unsigned($signed(alu_a) >>> alu_b[0]);
         4'd8: alu_result = alu_a >> alu_b[0];
         default: alu_result = 32'd0;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req0_valid = 1'b1; req0_a = 0; req0_b = 0; req0_func = 0;
      req1_valid = 1'b1; req1_a = 0; req1_b = 0; req1_func = 0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      tick(); tick();
      n_tests++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_err} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b want 000000",
                  {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_err});
      end
      n_tests++;
      if ({alu_a, alu_b, alu_func, rsp_data} !== 100'd0) begin
         n_fail++;
         $display("FAIL reset_data: a=%h b=%h f=%h d=%h want all 0",
                  alu_a, alu_b, alu_func, rsp_data);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_add();
      req0_valid = 1'b1; req0_a = 5; req0_b = 7; req0_func = 4'd0;
      #1;
      n_tests++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL add_ready: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
      end
      tick();
      req0_valid = 1'b0;
      n_tests++;
      if (busy !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd7 || alu_func !== 4'd0
          || req0_ready !== 1'b0 || rsp0_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL add_exec: busy=%b a=%0d b=%0d f=%0d rdy=%b v=%b want 1 5 7 0 0 0",
                  busy, alu_a, alu_b, alu_func, req0_ready, rsp0_valid);
      end
      tick();
      n_tests++;
      if (rsp0_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL add_early: rsp0_valid=%b want 0 after 1 edge", rsp0_valid);
      end
      tick();
      n_tests++;
      if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_data !== 32'd12
          || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL add_rsp: v0=%b v1=%b d=%0d e=%b want 1 0 12 0",
                  rsp0_valid, rsp1_valid, rsp_data, rsp_err);
      end
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL add_done: busy=%b v0=%b want 0 0", busy, rsp0_valid);
      end
   endtask

   task automatic test_illegal();
      req1_valid = 1'b1; req1_a = 32'h1234; req1_b = 32'h5678; req1_func = 4'hA;
      #1;
      n_tests++;
      if (req1_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ill_ready: req1_ready=%b want 1", req1_ready);
      end
      tick();
      req1_valid = 1'b0;
      n_tests++;
      if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_err !== 1'b1
          || rsp_data !== 32'd0) begin
         n_fail++;
         $display("FAIL ill_rsp: v1=%b v0=%b e=%b d=%h want 1 0 1 0",
                  rsp1_valid, rsp0_valid, rsp_err, rsp_data);
      end
      n_tests++;
      if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_func !== 4'd0) begin
         n_fail++;
         $display("FAIL ill_alu: a=%h b=%h f=%h want 5 7 0", alu_a, alu_b, alu_func);
      end
      rsp1_ready = 1'b1;
      tick();
      rsp1_ready = 1'b0;
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ill_done: busy=%b want 0", busy);
      end
   endtask

   task automatic test_round_robin();
      int g[$];
      int gc[$];
      int n0 = 0;
      int n1 = 0;
      req0_valid = 1'b1; req0_a = 10; req0_b = 3; req0_func = 4'd1;
      req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_func = 4'd4;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int cyc = 0; cyc < 24; cyc++) begin
         #1;
         if (req0_ready) begin g.push_back(0); gc.push_back(cyc); end
         if (req1_ready) begin g.push_back(1); gc.push_back(cyc); end
         if (rsp0_valid) begin
            n0++;
            n_tests++;
            if (rsp_data !== 32'd7 || rsp_err !== 1'b0) begin
               n_fail++;
               $display("FAIL rr_rsp0: d=%h e=%b want 7 0", rsp_data, rsp_err);
            end
         end
         if (rsp1_valid) begin
            n1++;
            n_tests++;
            if (rsp_data !== 32'hFF || rsp_err !== 1'b0) begin
               n_fail++;
               $display("FAIL rr_rsp1: d=%h e=%b want ff 0", rsp_data, rsp_err);
            end
         end
         @(posedge clk);
         #1;
         if (g.size() >= 4) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
      end
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      n_tests++;
      if (g.size() != 4 || n0 != 2 || n1 != 2) begin
         n_fail++;
         $display("FAIL rr_count: grants=%0d rsp0=%0d rsp1=%0d want 4 2 2",
                  g.size(), n0, n1);
      end else begin
         n_tests++;
         if (g[0] != 0 || g[1] != 1 || g[2] != 0 || g[3] != 1) begin
            n_fail++;
            $display("FAIL rr_order: got %0d%0d%0d%0d want 0101",
                     g[0], g[1], g[2], g[3]);
         end
         n_tests++;
         if (gc[1] - gc[0] != 4 || gc[2] - gc[1] != 4 || gc[3] - gc[2] != 4) begin
            n_fail++;
            $display("FAIL rr_gap: cycles %0d %0d %0d %0d want spacing 4",
                     gc[0], gc[1], gc[2], gc[3]);
         end
      end
   endtask

   task automatic test_backpressure();
      req0_valid = 1'b1; req0_a = 100; req0_b = 23; req0_func = 4'd0;
      req1_valid = 1'b1; req1_a = 32'hFF; req1_b = 32'h0F; req1_func = 4'd2;
      #1;
      n_tests++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_grant: r0=%b r1=%b want 1 0", req0_ready, req1_ready);
      end
      tick();
      req0_valid = 1'b0;
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (rsp0_valid !== 1'b1 || rsp_data !== 32'd123 || busy !== 1'b1
             || req1_ready !== 1'b0 || rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold%0d: v0=%b d=%0d busy=%b r1=%b v1=%b want 1 123 1 0 0",
                     i, rsp0_valid, rsp_data, busy, req1_ready, rsp1_valid);
         end
         tick();
      end
      rsp0_ready = 1'b1;
      #1;
      n_tests++;
      if (req1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_hs_cycle: req1_ready=%b want 0", req1_ready);
      end
      tick();
      rsp0_ready = 1'b0;
      #1;
      n_tests++;
      if (req1_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_next: req1_ready=%b want 1", req1_ready);
      end
      tick();
      req1_valid = 1'b0;
      tick(); tick();
      n_tests++;
      if (rsp1_valid !== 1'b1 || rsp_data !== 32'h0F || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_rsp1: v1=%b d=%h e=%b want 1 f 0", rsp1_valid, rsp_data, rsp_err);
      end
      rsp1_ready = 1'b1;
      tick();
      rsp1_ready = 1'b0;
   endtask

   task automatic test_funcs();
      logic [31:0] ta [7] = '{32'h0000FFFF, 32'h40000001, 32'h80000000,
                              32'h80000000, 32'h0000F0F0, 32'h000000F0, 32'd3};
      logic [31:0] tb [7] = '{32'd0, 32'd1, 32'd3, 32'd2, 32'h0000FF00,
                              32'h0000000F, 32'd5};
      logic [3:0]  tf [7] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd2, 4'd3, 4'd1};
      logic [31:0] te [7] = '{32'hFFFF0000, 32'h80000002, 32'hC0000000,
                              32'h80000000, 32'h0000F000, 32'h000000FF, 32'hFFFFFFFE};
      for (int k = 0; k < 7; k++) begin
         int w;
         req0_valid = 1'b1; req0_a = ta[k]; req0_b = tb[k]; req0_func = tf[k];
         tick();
         req0_valid = 1'b0;
         n_tests++;
         if (alu_func !== tf[k] || alu_a !== ta[k]) begin
            n_fail++;
            $display("FAIL fn%0d_alu: f=%0d a=%h want %0d %h", k, alu_func, alu_a, tf[k], ta[k]);
         end
         w = 0;
         while (rsp0_valid !== 1'b1 && w < 8) begin
            tick();
            w++;
         end
         n_tests++;
         if (rsp0_valid !== 1'b1 || rsp_data !== te[k] || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL fn%0d_rsp: v=%b d=%h e=%b want 1 %h 0",
                     k, rsp0_valid, rsp_data, rsp_err, te[k]);
         end
         rsp0_ready = 1'b1;
         tick();
         rsp0_ready = 1'b0;
      end
   endtask

   task automatic test_reset_midop();
      req0_valid = 1'b1; req0_a = 3; req0_b = 4; req0_func = 4'd3;
      tick();
      req0_valid = 1'b0;
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_busy: busy=%b want 1", busy);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({busy, rsp0_valid, rsp1_valid, rsp_err} !== 4'b0
          || {alu_a, alu_b, alu_func, rsp_data} !== 100'd0) begin
         n_fail++;
         $display("FAIL mid_rst: busy=%b v=%b%b e=%b a=%h b=%h f=%h d=%h want all 0",
                  busy, rsp0_valid, rsp1_valid, rsp_err, alu_a, alu_b, alu_func, rsp_data);
      end
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      n_tests++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_norsp: v0=%b v1=%b busy=%b want 0 0 0",
                  rsp0_valid, rsp1_valid, busy);
      end
      req0_valid = 1'b1; req0_a = 1; req0_b = 1; req0_func = 4'd0;
      req1_valid = 1'b1; req1_a = 2; req1_b = 2; req1_func = 4'd0;
      #1;
      n_tests++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_first: r0=%b r1=%b want 1 0", req0_ready, req1_ready);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_add();
      test_illegal();
      test_round_robin();
      test_backpressure();
      test_funcs();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
